// File: rtl/axis_sink_scoreboard.sv
// axis_sink_scoreboard: AXI4-Stream sink with selectable back-pressure and incrementing-pattern checking.
// Optional macro AXIS_SINK_PROTO_CHECK_EN compiles in the tvalid/payload stability check.
module axis_sink_scoreboard #(
    parameter int          DATA_W     = 32,
    parameter int          KEEP_W     = DATA_W / 8,
    parameter int          USER_W     = 1,
    parameter int          READY_MODE = 0,
    parameter int          READY_DUTY = 2,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1,
    parameter int          FRAME_LEN  = 16
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              enable,
    input  logic              clr,
    input  logic              s_axis_tvalid,
    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic [KEEP_W-1:0] s_axis_tkeep,
    input  logic              s_axis_tlast,
    input  logic [USER_W-1:0] s_axis_tuser,
    output logic              s_axis_tready,
    output logic [31:0]       beat_cnt,
    output logic [31:0]       frame_cnt,
    output logic [15:0]       last_frame_len,
    output logic [15:0]       data_err_cnt,
    output logic [15:0]       keep_err_cnt,
    output logic [15:0]       user_err_cnt,
    output logic [15:0]       len_err_cnt,
    output logic [15:0]       proto_err_cnt,
    output logic              err_flag
);
    function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic e);
        return (e && v != 16'hFFFF) ? v + 16'd1 : v;
    endfunction

    logic [7:0]  duty;
    logic [15:0] lfsr;
    logic        ready_src;

    always_comb ready_src = READY_MODE == 0 ? 1'b1 : READY_MODE == 1 ? duty == 8'd0 : lfsr[0];

    always_ff @(posedge aclk)
        if (!aresetn) begin
            s_axis_tready <= 1'b0;
            duty          <= '0;
            lfsr          <= LFSR_SEED;
        end else begin
            s_axis_tready <= enable && ready_src;
            duty          <= (duty == 8'(READY_DUTY - 1)) ? 8'd0 : duty + 8'd1;
            lfsr          <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        end

    logic              acc;
    logic [DATA_W-1:0] exp_word;
    logic [15:0]       in_cnt;
    logic [15:0]       frame_len;
    logic [KEEP_W-1:0] keep_inc;
    logic              data_ev, keep_ev, user_ev, len_ev, proto_ev;

    // A contiguous-from-LSB keep has no bit in common with itself plus one.
    always_comb begin
        acc       = s_axis_tvalid && s_axis_tready;
        keep_inc  = s_axis_tkeep + KEEP_W'(1);
        frame_len = (in_cnt == 16'hFFFF) ? in_cnt : in_cnt + 16'd1;
        data_ev   = acc && s_axis_tdata != exp_word;
        keep_ev   = acc && (s_axis_tlast ? (s_axis_tkeep == '0 || (s_axis_tkeep & keep_inc) != '0)
                                         : s_axis_tkeep != '1);
        user_ev   = acc && s_axis_tuser[0] != (in_cnt == 16'd0);
        len_ev    = acc && s_axis_tlast && FRAME_LEN != 0 && frame_len != 16'(FRAME_LEN);
    end

    logic        acc_q, last_q, data_q, keep_q, user_q, len_q, proto_q;
    logic [15:0] len_val_q;

    // Events are staged one cycle; clr squashes staged events so it also wins on the accepting edge.
    always_ff @(posedge aclk)
        if (!aresetn) begin
            exp_word  <= '0;
            in_cnt    <= '0;
            len_val_q <= '0;
            {acc_q, last_q, data_q, keep_q, user_q, len_q, proto_q} <= '0;
        end else begin
            if (acc) begin
                exp_word <= s_axis_tdata + DATA_W'(1);
                in_cnt   <= s_axis_tlast ? 16'd0 : frame_len;
            end
            {acc_q, last_q, data_q, keep_q, user_q, len_q, proto_q} <= clr ? 7'd0 :
                {acc, acc && s_axis_tlast, data_ev, keep_ev, user_ev, len_ev, proto_ev};
            len_val_q <= frame_len;
        end

    always_ff @(posedge aclk)
        if (!aresetn || clr) begin
            beat_cnt       <= '0;
            frame_cnt      <= '0;
            last_frame_len <= '0;
            data_err_cnt   <= '0;
            keep_err_cnt   <= '0;
            user_err_cnt   <= '0;
            len_err_cnt    <= '0;
            err_flag       <= 1'b0;
        end else begin
            beat_cnt     <= beat_cnt + 32'(acc_q);
            frame_cnt    <= frame_cnt + 32'(last_q);
            if (last_q) last_frame_len <= len_val_q;
            data_err_cnt <= sat_inc(data_err_cnt, data_q);
            keep_err_cnt <= sat_inc(keep_err_cnt, keep_q);
            user_err_cnt <= sat_inc(user_err_cnt, user_q);
            len_err_cnt  <= sat_inc(len_err_cnt, len_q);
            err_flag     <= err_flag | data_q | keep_q | user_q | len_q | proto_q;
        end

`ifdef AXIS_SINK_PROTO_CHECK_EN
    localparam int HOLD_W = DATA_W + KEEP_W + 1 + USER_W;

    logic              stall_q;
    logic [HOLD_W-1:0] hold_q, fields;

    always_comb begin
        fields   = {s_axis_tdata, s_axis_tkeep, s_axis_tlast, s_axis_tuser};
        proto_ev = stall_q && (!s_axis_tvalid || fields != hold_q);
    end

    always_ff @(posedge aclk)
        if (!aresetn) begin
            stall_q <= 1'b0;
            hold_q  <= '0;
        end else begin
            stall_q <= s_axis_tvalid && !s_axis_tready;
            if (s_axis_tvalid && !s_axis_tready) hold_q <= fields;
        end

    always_ff @(posedge aclk)
        if (!aresetn || clr) proto_err_cnt <= '0;
        else proto_err_cnt <= sat_inc(proto_err_cnt, proto_q);
`else
    always_comb proto_ev = 1'b0;
    assign proto_err_cnt = '0;
`endif
endmodule
